// File: rtl/scfifo_param.sv
// Parametrised single-clock FIFO with programmable thresholds, optional show-ahead
// read port, overflow/underflow pulses and synchronous clear.
module scfifo_param #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int AF_TH      = 2**ADDR_W - 2,
    parameter int AE_TH      = 2,
    parameter int SHOW_AHEAD = 0
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              clr,
    input  logic              wrreq,
    input  logic [DATA_W-1:0] data,
    input  logic              rdreq,
    output logic [DATA_W-1:0] q,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic [ADDR_W:0]   usedw,
    output logic              overflow,
    output logic              underflow
);

    localparam int              DEPTH     = 2**ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_LVL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_LVL    = (ADDR_W+1)'(AF_TH);
    localparam logic [ADDR_W:0] AE_LVL    = (ADDR_W+1)'(AE_TH);
    localparam logic [ADDR_W-1:0] PTR_STEP = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_STEP = {{ADDR_W{1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              wr_acc;
    logic              rd_acc;

    // Flags decode from the registered count; pointers wrap naturally and are never compared.
    assign empty        = (usedw == '0);
    assign full         = (usedw == DEPTH_LVL);
    assign almost_empty = (usedw <= AE_LVL);
    assign almost_full  = (usedw >= AF_LVL);

    // clr masks both requests so it wins over any simultaneous access.
    assign wr_acc = wrreq & ~full  & ~clr;
    assign rd_acc = rdreq & ~empty & ~clr;

    always_ff @(posedge sys_clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= data;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            usedw     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            usedw     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_STEP;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_STEP;
            end
            case ({wr_acc, rd_acc})
                2'b10:   usedw <= usedw + CNT_STEP;
                2'b01:   usedw <= usedw - CNT_STEP;
                default: usedw <= usedw;
            endcase
            overflow  <= wrreq & full;
            underflow <= rdreq & empty;
        end
    end

    generate
        if (SHOW_AHEAD != 0) begin : g_show_ahead
            // Head word is presented combinationally; forced to zero while empty.
            assign q = empty ? '0 : mem[rd_ptr];
        end else begin : g_normal
            always_ff @(posedge sys_clk or posedge sys_rst) begin
                if (sys_rst) begin
                    q <= '0;
                end else if (rd_acc) begin
                    q <= mem[rd_ptr];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_scfifo_param.sv
// Directed bench for scfifo_param: default-parameter reset check plus 16-deep
// normal-mode and show-ahead instances driven from shared stimulus.
module tb_scfifo_param;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       clr     = 1'b0;
    logic       wrreq   = 1'b0;
    logic       rdreq   = 1'b0;
    logic [7:0] data    = 8'h00;

    logic [7:0] q0, q1, qd;
    logic       empty0, full0, ae0, af0, ov0, un0;
    logic       empty1, full1, ae1, af1, ov1, un1;
    logic       emptyd, fulld, aed, afd, ovd, und;
    logic [4:0] usedw0, usedw1;
    logic [8:0] usedwd;

    int errors = 0;
    int checks = 0;

    always #5 sys_clk = ~sys_clk;

    scfifo_param #(.DATA_W(8), .ADDR_W(4), .SHOW_AHEAD(0)) dut0 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .clr(clr), .wrreq(wrreq), .data(data),
        .rdreq(rdreq), .q(q0), .empty(empty0), .full(full0), .almost_empty(ae0),
        .almost_full(af0), .usedw(usedw0), .overflow(ov0), .underflow(un0));

    scfifo_param #(.DATA_W(8), .ADDR_W(4), .SHOW_AHEAD(1)) dut1 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .clr(clr), .wrreq(wrreq), .data(data),
        .rdreq(rdreq), .q(q1), .empty(empty1), .full(full1), .almost_empty(ae1),
        .almost_full(af1), .usedw(usedw1), .overflow(ov1), .underflow(un1));

    scfifo_param dut_def (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .clr(clr), .wrreq(wrreq), .data(data),
        .rdreq(rdreq), .q(qd), .empty(emptyd), .full(fulld), .almost_empty(aed),
        .almost_full(afd), .usedw(usedwd), .overflow(ovd), .underflow(und));

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        sys_rst = 1'b1; clr = 1'b0; wrreq = 1'b0; rdreq = 1'b0; data = 8'h00;
        tick();
        sys_rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            checks++;
            if ({emptyd, fulld, aed, afd, ovd, und} !== 6'b101000) begin
                errors++;
                $display("FAIL reset_flags cyc %0d: got e/f/ae/af/ov/un=%b want 101000", c,
                         {emptyd, fulld, aed, afd, ovd, und});
            end
            checks++;
            if (usedwd !== 9'd0 || qd !== 8'h00) begin
                errors++;
                $display("FAIL reset_usedw_q cyc %0d: got usedw=%0d q=%h want 0/00", c, usedwd, qd);
            end
            tick();
        end
    endtask

    task automatic test_fill_drain();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            wrreq = 1'b1; data = 8'(i);
            tick();
            checks++;
            if (usedw0 !== 5'(i + 1) || af0 !== (i + 1 >= 14) || full0 !== (i == 15)
                || ae0 !== (i + 1 <= 2)) begin
                errors++;
                $display("FAIL fill_%0d: got usedw=%0d af=%b full=%b ae=%b want %0d %b %b %b",
                         i, usedw0, af0, full0, ae0, i + 1, (i + 1 >= 14), (i == 15), (i + 1 <= 2));
            end
        end
        data = 8'hAA;
        tick();
        checks++;
        if (ov0 !== 1'b1 || usedw0 !== 5'd16) begin
            errors++;
            $display("FAIL overflow_pulse: got ov=%b usedw=%0d want 1/16", ov0, usedw0);
        end
        wrreq = 1'b0;
        tick();
        checks++;
        if (ov0 !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clear: got ov=%b want 0", ov0);
        end
        for (int i = 0; i < 16; i++) begin
            rdreq = 1'b1;
            tick();
            checks++;
            if (q0 !== 8'(i) || usedw0 !== 5'(15 - i)) begin
                errors++;
                $display("FAIL drain_%0d: got q=%h usedw=%0d want %h %0d", i, q0, usedw0, 8'(i), 15 - i);
            end
        end
        rdreq = 1'b0;
        checks++;
        if (empty0 !== 1'b1 || full0 !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty: got empty=%b full=%b want 1/0", empty0, full0);
        end
    endtask

    task automatic test_underflow();
        rdreq = 1'b1;
        tick();
        checks++;
        if (un0 !== 1'b1 || usedw0 !== 5'd0 || q0 !== 8'h0F) begin
            errors++;
            $display("FAIL underflow_pulse: got un=%b usedw=%0d q=%h want 1/0/0f", un0, usedw0, q0);
        end
        rdreq = 1'b0;
        tick();
        checks++;
        if (un0 !== 1'b0) begin
            errors++;
            $display("FAIL underflow_clear: got un=%b want 0", un0);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            wrreq = 1'b1; data = 8'h10 + 8'(i);
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            wrreq = 1'b1; rdreq = 1'b1; data = 8'h20 + 8'(i);
            tick();
            exp_q = (i < 5) ? 8'h10 + 8'(i) : 8'h20 + 8'(i - 5);
            checks++;
            if (q0 !== exp_q || usedw0 !== 5'd5) begin
                errors++;
                $display("FAIL simul_%0d: got q=%h usedw=%0d want %h 5", i, q0, usedw0, exp_q);
            end
        end
        wrreq = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (q0 !== 8'h2F + 8'(i)) begin
                errors++;
                $display("FAIL simul_tail_%0d: got q=%h want %h", i, q0, 8'h2F + 8'(i));
            end
        end
        rdreq = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wrreq = 1'b1; data = 8'h40 + 8'(i);
            tick();
        end
        rdreq = 1'b1; data = 8'hEE;
        tick();
        checks++;
        if (usedw0 !== 5'd15 || ov0 !== 1'b1 || q0 !== 8'h40) begin
            errors++;
            $display("FAIL simul_full: got usedw=%0d ov=%b q=%h want 15/1/40", usedw0, ov0, q0);
        end
        wrreq = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        wrreq = 1'b1; data = 8'h99;
        tick();
        checks++;
        if (usedw0 !== 5'd1 || un0 !== 1'b1 || q0 !== 8'h4F) begin
            errors++;
            $display("FAIL simul_empty: got usedw=%0d un=%b q=%h want 1/1/4f", usedw0, un0, q0);
        end
        wrreq = 1'b0; rdreq = 1'b1;
        tick();
        rdreq = 1'b0;
        checks++;
        if (q0 !== 8'h99 || empty0 !== 1'b1) begin
            errors++;
            $display("FAIL simul_no_bypass: got q=%h empty=%b want 99/1", q0, empty0);
        end
    endtask

    task automatic test_show_ahead();
        do_reset();
        wrreq = 1'b1; data = 8'h3C;
        tick();
        checks++;
        if (empty1 !== 1'b0 || q1 !== 8'h3C) begin
            errors++;
            $display("FAIL sa_first: got empty=%b q=%h want 0/3c", empty1, q1);
        end
        data = 8'h5A;
        tick();
        checks++;
        if (q1 !== 8'h3C || usedw1 !== 5'd2) begin
            errors++;
            $display("FAIL sa_hold: got q=%h usedw=%0d want 3c/2", q1, usedw1);
        end
        wrreq = 1'b0; rdreq = 1'b1;
        tick();
        checks++;
        if (q1 !== 8'h5A || usedw1 !== 5'd1) begin
            errors++;
            $display("FAIL sa_pop: got q=%h usedw=%0d want 5a/1", q1, usedw1);
        end
        tick();
        rdreq = 1'b0;
        checks++;
        if (empty1 !== 1'b1 || un1 !== 1'b0) begin
            errors++;
            $display("FAIL sa_empty: got empty=%b un=%b want 1/0", empty1, un1);
        end
    endtask

    task automatic test_clr();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            wrreq = 1'b1; data = 8'h60 + 8'(i);
            tick();
        end
        wrreq = 1'b0; rdreq = 1'b1;
        tick();
        clr = 1'b1; wrreq = 1'b1; rdreq = 1'b1; data = 8'h77;
        tick();
        clr = 1'b0; wrreq = 1'b0; rdreq = 1'b0;
        checks++;
        if (usedw0 !== 5'd0 || empty0 !== 1'b1 || ov0 !== 1'b0 || un0 !== 1'b0) begin
            errors++;
            $display("FAIL clr_state: got usedw=%0d empty=%b ov=%b un=%b want 0/1/0/0",
                     usedw0, empty0, ov0, un0);
        end
        checks++;
        if (q0 !== 8'h60) begin
            errors++;
            $display("FAIL clr_q_hold: got q=%h want 60", q0);
        end
        tick();
        checks++;
        if (usedw0 !== 5'd0 || un0 !== 1'b0) begin
            errors++;
            $display("FAIL clr_after: got usedw=%0d un=%b want 0/0", usedw0, un0);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            wrreq = 1'b1; data = 8'h70 + 8'(i);
            tick();
        end
        wrreq = 1'b0; rdreq = 1'b1;
        tick();
        rdreq = 1'b0; wrreq = 1'b1; data = 8'h73;
        #2 sys_rst = 1'b1;
        #1;
        checks++;
        if (usedw0 !== 5'd0 || empty0 !== 1'b1 || q0 !== 8'h00 || ae0 !== 1'b1) begin
            errors++;
            $display("FAIL async_rst: got usedw=%0d empty=%b q=%h ae=%b want 0/1/00/1",
                     usedw0, empty0, q0, ae0);
        end
        checks++;
        if (usedw1 !== 5'd0 || empty1 !== 1'b1) begin
            errors++;
            $display("FAIL async_rst_sa: got usedw=%0d empty=%b want 0/1", usedw1, empty1);
        end
        #1 sys_rst = 1'b0; wrreq = 1'b0;
        tick();
        checks++;
        if (usedw0 !== 5'd0 || q0 !== 8'h00) begin
            errors++;
            $display("FAIL async_rst_after: got usedw=%0d q=%h want 0/00", usedw0, q0);
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_underflow();
        test_back_to_back();
        test_show_ahead();
        test_clr();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scfifo_param.md
Name: scfifo_param

Overview:
Parametrised single-clock FIFO. It is the successor to the fixed 256x8 scfifo instance and is written in plain RTL with no vendor IP. It generalises width and depth, and adds programmable almost-full/almost-empty thresholds, a show-ahead read mode, overflow/underflow error pulses and a synchronous clear. It sits between a data producer (pi_flag/pi_data style strobe) and a consumer in the sys_clk domain.

Parameters:
DATA_W, 8, data word width in bits
ADDR_W, 8, address width; DEPTH = 2**ADDR_W words
AF_TH, 2**ADDR_W-2, almost_full asserts when usedw >= AF_TH
AE_TH, 2, almost_empty asserts when usedw <= AE_TH
SHOW_AHEAD, 0, 0 = normal read (q after rdreq), 1 = head word presented on q while not empty

Ports:
sys_clk  in  1  system clock, all logic on rising edge
sys_rst  in  1  asynchronous, active-high reset
clr  in  1  synchronous clear; empties FIFO, memory contents don't-care
wrreq  in  1  write request
data  in  DATA_W  write data, sampled with wrreq
rdreq  in  1  read request (normal: fetch; show-ahead: acknowledge/pop head)
q  out  DATA_W  read data
empty  out  1  usedw == 0
full  out  1  usedw == DEPTH
almost_empty  out  1  usedw <= AE_TH
almost_full  out  1  usedw >= AF_TH
usedw  out  ADDR_W+1  words stored, 0..DEPTH (unlike the legacy 8-bit count, full is representable)
overflow  out  1  one-cycle pulse: wrreq while full and write not accepted
underflow  out  1  one-cycle pulse: rdreq while empty

Behaviour:
- Reset (sys_rst high, async): wr_ptr=rd_ptr=0, usedw=0, empty=1, full=0, almost_empty=1, almost_full=0 (unless AF_TH==0), overflow=underflow=0, q=0. Deassertion is used synchronously by the integrator. No requirement on the memory array.
- Accept rules: wr_acc = wrreq & !full; rd_acc = rdreq & !empty. Flags are decoded from the registered count/state.
- Simultaneous wr_acc & rd_acc: usedw unchanged; both pointers advance.
- Full + wrreq + rdreq: read accepted, write rejected, overflow=1; usedw becomes DEPTH-1.
- Empty + wrreq + rdreq: write accepted, read rejected, underflow=1; no write-through bypass.
- usedw: +1 on wr_acc only, -1 on rd_acc only. Flags, usedw and error pulses change only at the clock edge where the accepting request is sampled.
- Pointers: ADDR_W bits, wrap from DEPTH-1 to 0 naturally. full/empty come from the count, not the pointer compare.
- Normal mode (SHOW_AHEAD=0): on rd_acc at edge N, q <= mem[rd_ptr], valid after edge N (1-cycle latency, same as the legacy FIFO). q holds its last value when there is no rd_acc.
- Show-ahead mode (SHOW_AHEAD=1): whenever !empty, q = word at rd_ptr. rd_acc removes it and q shows the next word after the edge. First-word latency: write at edge N gives q valid and empty=0 after edge N. q is don't-care while empty.
- clr (sync): highest priority over wrreq/rdreq in the same cycle. Result equals reset state except q, which holds its value. No overflow/underflow pulse in the clr cycle.
- overflow/underflow are registered single-cycle pulses, cleared next cycle unless the condition repeats.
- Reset mid-operation: immediate return to reset values. Data in flight is lost.
- Legal parameters: ADDR_W >= 2, 0 <= AE_TH < AF_TH <= DEPTH. Other values are unsupported.

Test Plan:
- Reset/idle (defaults) -> empty=1, full=0, usedw=0, almost_empty=1, almost_full=0, q=0; hold 10 cycles with no change.
- ADDR_W=4, SHOW_AHEAD=0: write 0x00..0x0F in 16 cycles -> full=1, usedw=16, almost_full from usedw=14. Extra write of 0xAA -> overflow pulse 1 cycle, usedw stays 16. Read 16 -> q=0x00..0x0F, each 1 cycle after rdreq, then empty=1.
- Underflow: rdreq on an empty FIFO -> underflow=1 for one cycle, usedw=0, q unchanged.
- Simultaneous: usedw=5, wrreq&rdreq for 20 cycles -> usedw stays 5, pointers wrap past 15, data order preserved. At full with both requests -> usedw=15, overflow=1. At empty with both requests -> usedw=1, underflow=1.
- SHOW_AHEAD=1: write 0x3C -> after that edge empty=0, q=0x3C. Write 0x5A, then rdreq -> q=0x5A next cycle. rdreq again -> empty=1.
- clr with usedw=9 while wrreq=rdreq=1 -> next cycle usedw=0, empty=1, no error pulses. Async sys_rst mid-burst -> outputs at reset values before the next edge.
